// File: rtl/mxv_rx_pkg.sv
// Shared definitions for the matrix-vector command-frame receiver.
// States, known command codes and the default frame delimiters live here.
package mxv_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_CMD,
    ST_PAYLOAD,
    ST_CHK,
    ST_EOF,
    ST_DONE
  } rx_state_e;

  localparam logic [7:0] CMD_SIZE   = 8'h01;
  localparam logic [7:0] CMD_INIT   = 8'h03;
  localparam logic [7:0] CMD_MATRIX = 8'h04;

  localparam logic [7:0] SOF_CODE = 8'hFE;
  localparam logic [7:0] EOF_CODE = 8'hEF;

endpackage

// File: rtl/mxv_rx_byte_strobe.sv
// Turns the level-style UART byte-ready interrupt into a one-cycle strobe
// and produces the matching clear_interrupt pulse one cycle later.
// The edge register clears on reset, so an interrupt already high when
// reset is released is treated as a fresh byte.
module mxv_rx_byte_strobe (
  input  logic clk,
  input  logic reset,
  input  logic rx_interrupt,
  output logic strobe,
  output logic clear_interrupt
);

  logic rx_interrupt_q, rx_interrupt_d;
  logic clear_interrupt_q, clear_interrupt_d;

  assign strobe          = rx_interrupt & ~rx_interrupt_q;
  assign clear_interrupt = clear_interrupt_q;

  // Next values: remember the interrupt level and acknowledge every strobed byte.
  always_comb begin
    rx_interrupt_d    = rx_interrupt;
    clear_interrupt_d = rx_interrupt & ~rx_interrupt_q;
  end

  // Edge-detect history and registered acknowledge pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_interrupt_q    <= 1'b0;
      clear_interrupt_q <= 1'b0;
    end else begin
      rx_interrupt_q    <= rx_interrupt_d;
      clear_interrupt_q <= clear_interrupt_d;
    end
  end

endmodule

// File: rtl/mxv_frame_receiver.sv
// Command-frame parser between the UART receiver and the matrix-vector datapath.
// Frame: SOF, LEN, CMD, payload[LEN-2], (CHK), EOF. LEN counts LEN, CMD and payload.
// A complete frame is held on the outputs with frame_valid until frame_ack.
// Optional feature: define FRAME_CHECKSUM_EN to expect an XOR checksum byte
// (LEN ^ CMD ^ payload) just before EOF; otherwise err_chk is tied low.
module mxv_frame_receiver
  import mxv_rx_pkg::*;
#(
  parameter int                     WORD_LENGTH = 8,
  parameter int                     MAX_PAYLOAD = 16,
  parameter logic [WORD_LENGTH-1:0] SOF         = WORD_LENGTH'(SOF_CODE),
  parameter logic [WORD_LENGTH-1:0] EOF         = WORD_LENGTH'(EOF_CODE),
  parameter int                     TIMEOUT     = 1024
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               rx_interrupt,
  input  logic [WORD_LENGTH-1:0]             rx_data,
  output logic                               clear_interrupt,
  output logic                               frame_valid,
  input  logic                               frame_ack,
  output logic [WORD_LENGTH-1:0]             frame_cmd,
  output logic [WORD_LENGTH-1:0]             frame_len,
  output logic [$clog2(MAX_PAYLOAD+1)-1:0]   payload_count,
  output logic [MAX_PAYLOAD*WORD_LENGTH-1:0] payload,
  output logic                               err_len,
  output logic                               err_frame,
  output logic                               err_timeout,
  output logic                               err_chk,
  output logic                               err_overrun
);

  localparam int CW = $clog2(MAX_PAYLOAD + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WORD_LENGTH:0] MIN_LEN = (WORD_LENGTH+1)'(2);
  localparam logic [WORD_LENGTH:0] MAX_LEN = (WORD_LENGTH+1)'(MAX_PAYLOAD + 2);

`ifdef FRAME_CHECKSUM_EN
  localparam rx_state_e TAIL_STATE = ST_CHK;
`else
  localparam rx_state_e TAIL_STATE = ST_EOF;
`endif

  logic strobe;

  rx_state_e                        state_q, state_d;
  logic [WORD_LENGTH-1:0]           len_q, len_d;
  logic [WORD_LENGTH-1:0]           cmd_q, cmd_d;
  logic [CW-1:0]                    count_q, count_d;
  logic [CW-1:0]                    idx_q, idx_d;
  logic [MAX_PAYLOAD*WORD_LENGTH-1:0] payload_q, payload_d;
  logic [TW-1:0]                    timer_q, timer_d;
  logic                             frame_valid_q, frame_valid_d;
  logic                             err_len_q, err_len_d;
  logic                             err_frame_q, err_frame_d;
  logic                             err_timeout_q, err_timeout_d;
  logic                             err_overrun_q, err_overrun_d;
  logic [WORD_LENGTH:0]             len_ext;
  logic                             in_frame;
`ifdef FRAME_CHECKSUM_EN
  logic [WORD_LENGTH-1:0]           chk_q, chk_d;
  logic                             err_chk_q, err_chk_d;
`endif

  mxv_rx_byte_strobe u_strobe (
    .clk             (clk),
    .reset           (reset),
    .rx_interrupt    (rx_interrupt),
    .strobe          (strobe),
    .clear_interrupt (clear_interrupt)
  );

  assign frame_valid   = frame_valid_q;
  assign frame_cmd     = cmd_q;
  assign frame_len     = len_q;
  assign payload_count = count_q;
  assign payload       = payload_q;
  assign err_len       = err_len_q;
  assign err_frame     = err_frame_q;
  assign err_timeout   = err_timeout_q;
  assign err_overrun   = err_overrun_q;
`ifdef FRAME_CHECKSUM_EN
  assign err_chk       = err_chk_q;
`else
  assign err_chk       = 1'b0;
`endif

  // Frame parser: advance on each byte strobe, then apply the inter-byte timeout.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    cmd_d         = cmd_q;
    count_d       = count_q;
    idx_d         = idx_q;
    payload_d     = payload_q;
    timer_d       = '0;
    err_len_d     = 1'b0;
    err_frame_d   = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;
    len_ext       = {1'b0, rx_data};
    in_frame      = (state_q != ST_IDLE) && (state_q != ST_DONE);
`ifdef FRAME_CHECKSUM_EN
    chk_d         = chk_q;
    err_chk_d     = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (strobe && rx_data == SOF) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (strobe) begin
          if (len_ext < MIN_LEN || len_ext > MAX_LEN) begin
            err_len_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            len_d   = rx_data;
            count_d = CW'(rx_data - WORD_LENGTH'(2));
            state_d = ST_CMD;
`ifdef FRAME_CHECKSUM_EN
            chk_d   = rx_data;
`endif
          end
        end
      end
      ST_CMD: begin
        if (strobe) begin
          cmd_d     = rx_data;
          payload_d = '0;
          idx_d     = '0;
          state_d   = (count_q == '0) ? TAIL_STATE : ST_PAYLOAD;
`ifdef FRAME_CHECKSUM_EN
          chk_d     = chk_q ^ rx_data;
`endif
        end
      end
      ST_PAYLOAD: begin
        if (strobe) begin
          for (int i = 0; i < MAX_PAYLOAD; i++) begin
            if (idx_q == CW'(i)) payload_d[i*WORD_LENGTH +: WORD_LENGTH] = rx_data;
          end
          idx_d = idx_q + CW'(1);
          if (idx_q == count_q - CW'(1)) state_d = TAIL_STATE;
`ifdef FRAME_CHECKSUM_EN
          chk_d = chk_q ^ rx_data;
`endif
        end
      end
      ST_CHK: begin
`ifdef FRAME_CHECKSUM_EN
        if (strobe) begin
          if (rx_data == chk_q) begin
            state_d = ST_EOF;
          end else begin
            err_chk_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_EOF: begin
        if (strobe) begin
          if (rx_data == EOF) begin
            state_d = ST_DONE;
          end else begin
            err_frame_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        if (frame_ack) begin
          state_d = (strobe && rx_data == SOF) ? ST_LEN : ST_IDLE;
        end else if (strobe) begin
          err_overrun_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (TIMEOUT != 0 && in_frame && !strobe) begin
      timer_d = timer_q + TW'(1);
      if (timer_q == TW'(TIMEOUT - 1)) begin
        err_timeout_d = 1'b1;
        timer_d       = '0;
        state_d       = ST_IDLE;
      end
    end

    frame_valid_d = (state_d == ST_DONE);
  end

  // Parser state, frame contents and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      cmd_q         <= '0;
      count_q       <= '0;
      idx_q         <= '0;
      payload_q     <= '0;
      timer_q       <= '0;
      frame_valid_q <= 1'b0;
      err_len_q     <= 1'b0;
      err_frame_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      chk_q         <= '0;
      err_chk_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      cmd_q         <= cmd_d;
      count_q       <= count_d;
      idx_q         <= idx_d;
      payload_q     <= payload_d;
      timer_q       <= timer_d;
      frame_valid_q <= frame_valid_d;
      err_len_q     <= err_len_d;
      err_frame_q   <= err_frame_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
`ifdef FRAME_CHECKSUM_EN
      chk_q         <= chk_d;
      err_chk_q     <= err_chk_d;
`endif
    end
  end

endmodule
